// File: rtl/arqui_router.sv
// arqui_router: one input stream buffered in a main FIFO and routed by its
// top CH_BITS bits to 2**CH_BITS independently popped output FIFOs.
// A small FSM tracks reset/init/idle/active and a sticky error state.
module arqui_router #(
  parameter int DATA_WIDTH = 6,
  parameter int CH_BITS    = 1,
  parameter int MAIN_DEPTH = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                init,
  input  logic [$clog2(MAIN_DEPTH):0]         umbral_main,
  input  logic [$clog2(OUT_DEPTH):0]          umbral_out,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic [(2**CH_BITS)-1:0]             pop,
  output logic [(2**CH_BITS)*DATA_WIDTH-1:0]  data_out,
  output logic [(2**CH_BITS)-1:0]             valid_out,
  output logic [(2**CH_BITS)-1:0]             empty_out,
  output logic                                pause,
  output logic [2:0]                          state,
  output logic                                idle_out,
  output logic                                error_out
);
  localparam int NUM_CH = 2**CH_BITS;
  localparam int MA     = $clog2(MAIN_DEPTH);
  localparam int OA     = $clog2(OUT_DEPTH);
  localparam logic [MA:0] M_FULL = MAIN_DEPTH[MA:0];
  localparam logic [MA:0] M_DEF  = M_FULL - 1'b1;
  localparam logic [OA:0] O_FULL = OUT_DEPTH[OA:0];
  localparam logic [OA:0] O_DEF  = O_FULL - 1'b1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                   st;
  logic [MA:0]              thr_main, m_cnt, um_eff;
  logic [OA:0]              thr_out, uo_eff;
  logic [MA-1:0]            m_wptr, m_rptr;
  logic [DATA_WIDTH-1:0]    m_mem [MAIN_DEPTH];
  logic [DATA_WIDTH-1:0]    head;
  logic [CH_BITS-1:0]       head_ch;
  logic [NUM_CH-1:0][OA:0]  ch_cnt;
  logic [NUM_CH-1:0]        do_pop;
  logic live, overflow, underflow, go_err, run, do_push, do_xfer, all_empty;

  assign head    = m_mem[m_rptr];
  assign head_ch = head[DATA_WIDTH-1 -: CH_BITS];

  // Out-of-range thresholds fall back to depth-1
  assign um_eff = (umbral_main == '0 || umbral_main > M_FULL) ? M_DEF : umbral_main;
  assign uo_eff = (umbral_out  == '0 || umbral_out  > O_FULL) ? O_DEF : umbral_out;

  // An erroneous request freezes everything on the very edge it is seen
  assign live      = (st == S_IDLE) || (st == S_ACTIVE);
  assign overflow  = push && (m_cnt == M_FULL);
  assign underflow = |(pop & empty_out);
  assign go_err    = live && (overflow || underflow);
  assign run       = live && !overflow && !underflow;
  assign do_push   = run && push;
  assign do_pop    = run ? pop : '0;
  // In-order routing: a blocked head stalls every channel
  assign do_xfer   = run && (st == S_ACTIVE) && (m_cnt != '0) &&
                     (ch_cnt[head_ch] < thr_out);
  assign all_empty = (m_cnt == '0) && (&empty_out);

  assign pause     = m_cnt >= thr_main;
  assign state     = st;
  assign idle_out  = (st == S_IDLE);
  assign error_out = (st == S_ERROR);

  // Main FIFO storage (not reset; validity tracked by the count)
  always_ff @(posedge clk)
    if (do_push) m_mem[m_wptr] <= data_in;

  // Main FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wptr <= '0;
      m_rptr <= '0;
      m_cnt  <= '0;
    end else begin
      if (do_push) m_wptr <= m_wptr + 1'b1;
      if (do_xfer) m_rptr <= m_rptr + 1'b1;
      m_cnt <= m_cnt + {{MA{1'b0}}, do_push} - {{MA{1'b0}}, do_xfer};
    end
  end

  // Control FSM with threshold capture during INIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_RESET;
      thr_main <= M_DEF;
      thr_out  <= O_DEF;
    end else begin
      case (st)
        S_RESET: st <= S_INIT;
        S_INIT: begin
          thr_main <= um_eff;
          thr_out  <= uo_eff;
          if (!init) st <= S_IDLE;
        end
        S_IDLE: begin
          if (go_err)                       st <= S_ERROR;
          else if (init)                    st <= S_INIT;
          else if (push || m_cnt != '0)     st <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (go_err)                       st <= S_ERROR;
          else if (all_empty && !push)      st <= S_IDLE;
        end
        S_ERROR: st <= S_ERROR;
        default: st <= S_RESET;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
    logic [OA-1:0]         wp, rp;
    logic [OA:0]           cnt;
    logic [DATA_WIDTH-1:0] dout;
    logic                  vld, wr;

    assign wr = do_xfer && (head_ch == CH_BITS'(i));

    // Channel storage
    always_ff @(posedge clk)
      if (wr) mem[wp] <= head;

    // Channel pointers, occupancy and registered read port
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        dout <= '0;
        vld  <= 1'b0;
      end else begin
        if (wr) wp <= wp + 1'b1;
        if (do_pop[i]) begin
          dout <= mem[rp];
          rp   <= rp + 1'b1;
        end
        vld <= do_pop[i];
        cnt <= cnt + {{OA{1'b0}}, wr} - {{OA{1'b0}}, do_pop[i]};
      end
    end

    assign ch_cnt[i]                             = cnt;
    assign empty_out[i]                          = (cnt == '0);
    assign valid_out[i]                          = vld;
    assign data_out[i*DATA_WIDTH +: DATA_WIDTH]  = dout;
  end

endmodule

// File: doc/arqui_router.md
# arqui_router

Parametrised successor to the two-output FIFO/FSM architecture. One input word stream is buffered in a main FIFO and routed by a channel field to 2^CH_BITS per-channel output FIFOs, each popped independently. A control FSM sequences reset, threshold loading, idle/active tracking and a sticky error state. Upstream sees back-pressure through `pause`.

## Interface
- `DATA_WIDTH`, 6: word width; top `CH_BITS` bits are the channel select, carried unchanged to the output.
- `CH_BITS`, 1: channel-select width; `NUM_CH = 2**CH_BITS`.
- `MAIN_DEPTH`, 4: main FIFO depth, power of two, ≥2.
- `OUT_DEPTH`, 4: per-channel FIFO depth, power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `init`  in  1  threshold-load request.
- `umbral_main`  in  clog2(MAIN_DEPTH)+1  main pause threshold, sampled in INIT.
- `umbral_out`  in  clog2(OUT_DEPTH)+1  per-channel back-pressure threshold, sampled in INIT.
- `push`  in  1  write `data_in` into main FIFO.
- `data_in`  in  DATA_WIDTH  input word.
- `pop`  in  NUM_CH  per-channel read request.
- `data_out`  out  NUM_CH*DATA_WIDTH  packed registered outputs, channel i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_out`  out  NUM_CH  per-channel data valid.
- `empty_out`  out  NUM_CH  per-channel FIFO empty.
- `pause`  out  1  main FIFO at/above threshold.
- `state`  out  3  FSM state code.
- `idle_out`  out  1  high in IDLE.
- `error_out`  out  1  high in ERROR.

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET → INIT on the first clock after `reset` falls.
- INIT: latch `umbral_main`/`umbral_out` every cycle. Go to IDLE when `init`=0. `push`/`pop` are ignored.
- IDLE: all FIFOs empty. `init`=1 → INIT. Any main-FIFO content → ACTIVE.
- ACTIVE → IDLE when all FIFOs are empty and no push occurs. `init` is ignored.
- Any state except RESET/INIT → ERROR on overflow or underflow:
  - overflow: `push` with main count == MAIN_DEPTH;
  - underflow: `pop[i]` with channel i empty.
- ERROR: FIFOs frozen, no transfers, `valid_out`=0. Exit only via `reset`.
- Thresholds: value 0 or > depth means use the default. Defaults are MAIN_DEPTH-1 and OUT_DEPTH-1.
- `pause` = main count ≥ umbral_main (combinational from registered count).
- Transfer: each cycle in ACTIVE, if main is non-empty and the head word's channel c has count < umbral_out, pop main and push into channel c. At most one transfer per cycle. A blocked head blocks all channels (in-order, no bypass).
- `pop[i]` on a non-empty channel: head word goes to `data_out[i]` with `valid_out[i]`=1 for one cycle. `data_out[i]` then holds its value while `valid_out[i]`=0.
- Pops on several channels in the same cycle are all served.
- Same-cycle events:
  - push together with transfer on main is allowed;
  - pop together with transfer on one channel is allowed; counts are net.

## Timing
- Reset (asynchronous) values:
  - `state`=RESET, all counts/pointers 0;
  - `data_out`=0, `valid_out`=0, `empty_out`=all 1s;
  - `pause`=0, `idle_out`=0, `error_out`=0;
  - thresholds = defaults.
- Push at edge t: word counted in main after t. Earliest transfer at t+1. Earliest pop at t+2. `data_out` valid after edge t+2.
- Pop-to-data latency is 1 cycle. Full throughput is one word/cycle.
- `reset` mid-operation: all contents discarded immediately, without waiting for a clock edge.
- Pointers wrap modulo depth. Counts are one bit wider than the pointers.

## Test plan
- Reset then `init`=1 for 2 cycles with `umbral_main`=3, `umbral_out`=2, then `init`=0 → states 0,1,1,2; `idle_out`=1; `empty_out`=4'b.. all 1s (2'b11 at CH_BITS=1).
- Push 6'b000101 and 6'b100111 on consecutive cycles, then pop both channels at t+3 → `data_out` = {6'b100111, 6'b000101}, `valid_out`=2'b11 for one cycle; state returns to IDLE.
- Push 5 words to channel 0 without popping, `umbral_out`=2 → channel 0 holds 2 words; main holds 3 and `pause`=1; no overflow.
- Push with main count 4 (MAIN_DEPTH=4) → `error_out`=1, `state`=4. Further push/pop changes nothing until `reset`.
- Pop channel 1 while empty → ERROR on the next edge.
- Fill 2 words, assert `reset` between clock edges → all outputs return to reset values before the next edge; the FSM passes through INIT again.
